// File: rtl/mem_pkg.sv
// Shared types and constants for the unified program/data memory port.
package mem_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  typedef enum logic [0:0] {
    PRI_EX = 1'b0,
    PRI_IF = 1'b1
  } arb_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spram_256x8.sv
// Single-port 256x8 synchronous RAM, one-cycle read latency, no reset on contents.
module spram_256x8
  import mem_pkg::*;
#(
  parameter INIT_FILE = "dedotated_wam.mif"
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [MEM_DW-1:0] wdata,
  output logic [MEM_DW-1:0] rdata
);

  (* ram_init_file = INIT_FILE *) logic [MEM_DW-1:0] mem_q [0:(1<<MEM_AW)-1];
  logic [MEM_DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and execute load/store,
// data first, with a bounded data run before a fetch is forced through.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter              INIT_FILE    = "dedotated_wam.mif"
) (
  input  logic              sig_clk,
  input  logic              sig_rst_n,
  input  logic              IF_sig_req,
  input  logic [MEM_AW-1:0] IF_addr_pgm,
  output logic              IF_sig_ack,
  output logic              IF_sig_valid,
  output logic [MEM_DW-1:0] ID_EX_data_pgm,
  input  logic              EX_sig_req,
  input  logic              EX_sig_we,
  input  logic [MEM_AW-1:0] EX_addr_data,
  input  logic [MEM_DW-1:0] EX_data_wr,
  output logic              EX_sig_ack,
  output logic              EX_sig_valid,
  output logic [MEM_DW-1:0] EX_data_rd,
  output logic              IF_sig_stall,
  output logic [7:0]        stat_conflicts
);

  localparam logic [3:0] RUN_LAST = 4'(MAX_DATA_RUN - 1);

  arb_state_t        state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic              if_vld_q, ex_vld_q;
  logic [MEM_DW-1:0] pgm_hold_q, ex_hold_q;
  logic [7:0]        stat_q;

  logic              grant_if, grant_ex, both_req;
  logic              ram_en, ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [MEM_DW-1:0] ram_rdata;

  assign both_req = IF_sig_req & EX_sig_req;
  assign grant_if = sig_rst_n & IF_sig_req & (~EX_sig_req | (state_q == PRI_IF));
  assign grant_ex = sig_rst_n & EX_sig_req & ~grant_if;

  assign ram_en   = grant_if | grant_ex;
  assign ram_we   = grant_ex & EX_sig_we;
  assign ram_addr = grant_ex ? EX_addr_data : IF_addr_pgm;

  spram_256x8 #(.INIT_FILE(INIT_FILE)) u_ram (
    .clk  (sig_clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(EX_data_wr),
    .rdata(ram_rdata)
  );

  // The run only counts data grants that actually made fetch wait.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      PRI_EX: begin
        if (grant_ex && IF_sig_req) begin
          if (run_q == RUN_LAST) begin
            state_d = PRI_IF;
            run_d   = 4'd0;
          end else begin
            run_d = run_q + 4'd1;
          end
        end else begin
          run_d = 4'd0;
        end
      end
      PRI_IF: begin
        if (grant_if || !IF_sig_req) begin
          state_d = PRI_EX;
          run_d   = 4'd0;
        end
      end
      default: begin
        state_d = PRI_EX;
        run_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) begin
      state_q    <= PRI_EX;
      run_q      <= 4'd0;
      if_vld_q   <= 1'b0;
      ex_vld_q   <= 1'b0;
      pgm_hold_q <= '0;
      ex_hold_q  <= '0;
      stat_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      if_vld_q <= grant_if;
      ex_vld_q <= grant_ex & ~EX_sig_we;
      if (if_vld_q) pgm_hold_q <= ram_rdata;
      if (ex_vld_q) ex_hold_q  <= ram_rdata;
      if (both_req) stat_q     <= sat_inc8(stat_q);
    end
  end

  // The RAM output register is shared, so each consumer latches it only
  // in the cycle right after its own grant and holds it afterwards.
  assign ID_EX_data_pgm = if_vld_q ? ram_rdata : pgm_hold_q;
  assign EX_data_rd     = ex_vld_q ? ram_rdata : ex_hold_q;

  assign IF_sig_ack     = grant_if;
  assign EX_sig_ack     = grant_ex;
  assign IF_sig_stall   = sig_rst_n & IF_sig_req & ~grant_if;
  assign IF_sig_valid   = if_vld_q;
  assign EX_sig_valid   = ex_vld_q;
  assign stat_conflicts = stat_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

  localparam int MAX_RUN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IF_req = 1'b0;
  logic [7:0] IF_addr = 8'h00;
  logic       EX_req = 1'b0;
  logic       EX_we = 1'b0;
  logic [7:0] EX_addr = 8'h00;
  logic [7:0] EX_wd = 8'h00;

  logic       IF_ack, IF_vld, EX_ack, EX_vld, IF_stall;
  logic [7:0] IF_data, EX_rd, stat;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_RUN(MAX_RUN)) dut (
    .sig_clk       (clk),
    .sig_rst_n     (rst_n),
    .IF_sig_req    (IF_req),
    .IF_addr_pgm   (IF_addr),
    .IF_sig_ack    (IF_ack),
    .IF_sig_valid  (IF_vld),
    .ID_EX_data_pgm(IF_data),
    .EX_sig_req    (EX_req),
    .EX_sig_we     (EX_we),
    .EX_addr_data  (EX_addr),
    .EX_data_wr    (EX_wd),
    .EX_sig_ack    (EX_ack),
    .EX_sig_valid  (EX_vld),
    .EX_data_rd    (EX_rd),
    .IF_sig_stall  (IF_stall),
    .stat_conflicts(stat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: priority flag, streak of data grants that made fetch wait,
  // memory image with a per-byte "known" flag, and the last delivered bytes.
  bit         m_pri_if;
  int         m_streak;
  int         m_stat;
  logic [7:0] m_mem [256];
  bit         m_known [256];
  bit         m_if_vld, m_ex_vld, m_if_k, m_ex_k;
  logic [7:0] m_if_d, m_ex_d;
  bit         e_if, e_ex;

  task automatic model_reset();
    m_pri_if = 1'b0;
    m_streak = 0;
    m_stat   = 0;
    m_if_vld = 1'b0;
    m_ex_vld = 1'b0;
    m_if_d   = 8'h00;
    m_ex_d   = 8'h00;
    m_if_k   = 1'b1;
    m_ex_k   = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    model_reset();
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_ack", IF_ack, 0);
      chk("rst_ex_ack", EX_ack, 0);
      chk("rst_stall", IF_stall, 0);
      chk("rst_if_vld", IF_vld, 0);
      chk("rst_ex_vld", EX_vld, 0);
      chk("rst_if_data", IF_data, 0);
      chk("rst_ex_data", EX_rd, 0);
      chk("rst_stat", stat, 0);
      model_reset();
    end else begin
      e_if = IF_req && (!EX_req || m_pri_if);
      e_ex = EX_req && !e_if;
      chk("if_ack", IF_ack, e_if);
      chk("ex_ack", EX_ack, e_ex);
      chk("if_stall", IF_stall, IF_req && !e_if);
      chk("if_vld", IF_vld, m_if_vld);
      chk("ex_vld", EX_vld, m_ex_vld);
      if (m_if_k) chk("if_data", IF_data, m_if_d);
      if (m_ex_k) chk("ex_data", EX_rd, m_ex_d);
      chk("stat", stat, m_stat);

      if (m_pri_if) begin
        m_pri_if = 1'b0;
        m_streak = 0;
      end else if (e_ex && IF_req) begin
        m_streak++;
        if (m_streak == MAX_RUN) begin
          m_pri_if = 1'b1;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      if (IF_req && EX_req && m_stat < 255) m_stat++;

      m_if_vld = e_if;
      if (e_if) begin
        m_if_d = m_mem[IF_addr];
        m_if_k = m_known[IF_addr];
      end
      m_ex_vld = e_ex && !EX_we;
      if (m_ex_vld) begin
        m_ex_d = m_mem[EX_addr];
        m_ex_k = m_known[EX_addr];
      end
      if (e_ex && EX_we) begin
        m_mem[EX_addr]   = EX_wd;
        m_known[EX_addr] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_req = 1'b0;
    EX_req = 1'b0;
    EX_we  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ex_store(input logic [7:0] a, input logic [7:0] d);
    EX_req = 1'b1; EX_we = 1'b1; EX_addr = a; EX_wd = d;
    tick();
    EX_req = 1'b0; EX_we = 1'b0;
  endtask

  bit ifa, exa;

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("t0_rst_stat", stat, 0);
    chk("t0_rst_ex_vld", EX_vld, 0);
    tick();
    rst_n = 1'b1;

    // Test 1: fetch right after reset release, RAM content survives reset
    ex_store(8'h10, 8'hA5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    IF_req = 1'b1; IF_addr = 8'h10;
    @(negedge clk);
    chk("t1_if_ack", IF_ack, 1);
    chk("t1_stall", IF_stall, 0);
    tick();
    IF_req = 1'b0;
    @(negedge clk);
    chk("t1_if_vld", IF_vld, 1);
    chk("t1_if_data", IF_data, 8'hA5);

    // Test 2: store then load
    tick();
    EX_req = 1'b1; EX_we = 1'b1; EX_addr = 8'h80; EX_wd = 8'h3C;
    @(negedge clk);
    chk("t2_st_ack", EX_ack, 1);
    tick();
    EX_we = 1'b0;
    @(negedge clk);
    chk("t2_st_novld", EX_vld, 0);
    chk("t2_ld_ack", EX_ack, 1);
    tick();
    EX_req = 1'b0;
    IF_req = 1'b1; IF_addr = 8'h10;
    @(negedge clk);
    chk("t2_ld_vld", EX_vld, 1);
    chk("t2_ld_data", EX_rd, 8'h3C);
    tick();
    IF_req = 1'b0;
    @(negedge clk);
    chk("t2_hold_ex", EX_rd, 8'h3C);
    chk("t2_hold_if", IF_data, 8'hA5);
    tick();

    // Test 3: starvation guard with MAX_DATA_RUN = 4
    do_reset();
    IF_req = 1'b1; IF_addr = 8'h05;
    EX_req = 1'b1; EX_we = 1'b0; EX_addr = 8'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_ex_run_ack", EX_ack, 1);
      chk("t3_stall", IF_stall, 1);
      tick();
    end
    @(negedge clk);
    chk("t3_forced_if", IF_ack, 1);
    chk("t3_ex_wait", EX_ack, 0);
    tick();
    IF_req = 1'b0;
    @(negedge clk);
    chk("t3_ex_again", EX_ack, 1);
    chk("t3_stat", stat, 5);
    tick();
    idle();

    // Test 4: conflict counter saturates
    do_reset();
    IF_req = 1'b1; IF_addr = 8'h10;
    EX_req = 1'b1; EX_we = 1'b0; EX_addr = 8'h80;
    repeat (300) tick();
    @(negedge clk);
    chk("t4_stat_sat", stat, 255);
    tick();
    idle();

    // Test 5: async reset the cycle after a load grant
    tick();
    ex_store(8'h40, 8'h77);
    EX_req = 1'b1; EX_we = 1'b0; EX_addr = 8'h40;
    tick();
    chk("t5_pre_vld", EX_vld, 1);
    EX_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_vld_clr", EX_vld, 0);
    chk("t5_data_clr", EX_rd, 0);
    tick();
    rst_n = 1'b1;
    IF_req = 1'b1; IF_addr = 8'h10;
    EX_req = 1'b1; EX_we = 1'b0; EX_addr = 8'h40;
    @(negedge clk);
    chk("t5_pri_ex", EX_ack, 1);
    tick();
    EX_req = 1'b0;
    @(negedge clk);
    chk("t5_reload_vld", EX_vld, 1);
    chk("t5_reload_data", EX_rd, 8'h77);
    tick();
    idle();

    // Test 6: fetch aborts while it holds priority
    do_reset();
    IF_req = 1'b1; IF_addr = 8'h10;
    EX_req = 1'b1; EX_we = 1'b0; EX_addr = 8'h80;
    repeat (4) tick();
    IF_req = 1'b0;
    @(negedge clk);
    chk("t6_ex_ack", EX_ack, 1);
    chk("t6_if_noack", IF_ack, 0);
    tick();
    IF_req = 1'b1;
    @(negedge clk);
    chk("t6_no_if_vld", IF_vld, 0);
    chk("t6_back_pri_ex", EX_ack, 1);
    tick();
    idle();
    tick();

    // Randomized traffic
    for (int a = 8'hF0; a <= 8'hFF; a++) ex_store(8'(a), 8'($urandom_range(255)));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ifa = IF_ack;
      exa = EX_ack;
      tick();
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        if (IF_req && !ifa) begin
          if ($urandom_range(15) == 0) IF_req = 1'b0;
        end else begin
          IF_req  = 1'($urandom_range(1));
          IF_addr = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : 8'($urandom_range(255, 240));
        end
        if (EX_req && !exa) begin
          if ($urandom_range(15) == 0) EX_req = 1'b0;
        end else begin
          EX_req  = 1'($urandom_range(1));
          EX_we   = 1'($urandom_range(1));
          EX_addr = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : 8'($urandom_range(255, 240));
          EX_wd   = 8'($urandom_range(255));
        end
      end
    end
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
